// File: rtl/gps_round_sequencer.sv
// Round sequencer around the GPS code generator: pulses start_round, waits for the
// generator's l_code_valid, and presents each captured round on a valid/ready port.
module gps_round_sequencer #(
  parameter int unsigned START_PULSE    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         sys_clk,
  input  logic         sync_rst_in,
  input  logic         run_req,
  input  logic [7:0]   num_rounds,
  input  logic         abort,
  output logic         busy,
  output logic         start_round,
  input  logic [12:0]  gps_ca_code,
  input  logic [127:0] gps_p_code,
  input  logic [127:0] gps_l_code,
  input  logic         gps_l_code_valid,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [12:0]  out_ca_code,
  output logic [127:0] out_p_code,
  output logic [127:0] out_l_code,
  output logic [7:0]   out_round_idx,
  output logic         done,
  output logic         timeout_err
);

  localparam logic [15:0] PulseLast   = 16'(START_PULSE - 1);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StHold} state_e;

  state_e         r_state, w_state_next;
  logic [15:0]    r_cnt;
  logic [7:0]     r_rounds_left, r_round_idx;
  logic           r_start_round, r_out_valid, r_done, r_timeout_err;
  logic [12:0]    r_ca;
  logic [127:0]   r_p, r_l;
  logic [7:0]     r_idx_out;
  logic           w_run_go, w_run_zero, w_capture, w_timeout, w_hs, w_last, w_abort, w_busy;

  // State register
  always_ff @(posedge sys_clk) begin
    if (sync_rst_in) r_state <= StIdle;
    else             r_state <= w_state_next;
  end

  // Next-state logic; abort outranks every other event outside IDLE
  always_comb begin
    w_state_next = r_state;
    w_run_go     = 1'b0;
    w_run_zero   = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    w_hs         = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      StIdle: begin
        if (run_req) begin
          if (num_rounds != 8'd0) begin
            w_run_go     = 1'b1;
            w_state_next = StStart;
          end else begin
            w_run_zero = 1'b1;
          end
        end
      end
      StStart: begin
        if (abort)                   w_state_next = StIdle;
        else if (r_cnt == PulseLast) w_state_next = StWait;
      end
      StWait: begin
        if (abort) begin
          w_state_next = StIdle;
        end else if (gps_l_code_valid) begin
          w_capture    = 1'b1;
          w_state_next = StHold;
        end else if (r_cnt == TimeoutLast) begin
          w_timeout    = 1'b1;
          w_state_next = StIdle;
        end
      end
      StHold: begin
        if (abort) begin
          w_state_next = StIdle;
        end else if (r_out_valid && out_ready) begin
          w_hs = 1'b1;
          if (r_rounds_left == 8'd1) begin
            w_last       = 1'b1;
            w_state_next = StIdle;
          end else begin
            w_state_next = StStart;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    w_busy  = (r_state != StIdle);
    w_abort = abort && (r_state != StIdle);
  end

  // Shared START/WAIT timer, restarted on every state change
  always_ff @(posedge sys_clk) begin
    if (sync_rst_in || (w_state_next != r_state)) r_cnt <= 16'd0;
    else if (r_state != StIdle)                   r_cnt <= r_cnt + 16'd1;
  end

  always_ff @(posedge sys_clk) begin
    if (sync_rst_in) begin
      r_rounds_left <= 8'd0;
      r_round_idx   <= 8'd0;
      r_start_round <= 1'b0;
      r_out_valid   <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_ca          <= 13'd0;
      r_p           <= 128'd0;
      r_l           <= 128'd0;
      r_idx_out     <= 8'd0;
    end else begin
      r_start_round <= (w_state_next == StStart);
      r_done        <= w_run_zero | w_timeout | w_last;
      if (w_run_go) begin
        r_rounds_left <= num_rounds;
        r_round_idx   <= 8'd0;
      end
      if (w_run_go || w_run_zero) r_timeout_err <= 1'b0;
      else if (w_timeout)         r_timeout_err <= 1'b1;
      if (w_capture) begin
        r_ca        <= gps_ca_code;
        r_p         <= gps_p_code;
        r_l         <= gps_l_code;
        r_idx_out   <= r_round_idx;
        r_out_valid <= 1'b1;
      end
      if (w_hs || w_abort) r_out_valid <= 1'b0;
      if (w_hs && !w_last) begin
        r_rounds_left <= r_rounds_left - 8'd1;
        r_round_idx   <= r_round_idx + 8'd1;
      end
    end
  end

  assign busy          = w_busy;
  assign start_round   = r_start_round;
  assign out_valid     = r_out_valid;
  assign out_ca_code   = r_ca;
  assign out_p_code    = r_p;
  assign out_l_code    = r_l;
  assign out_round_idx = r_idx_out;
  assign done          = r_done;
  assign timeout_err   = r_timeout_err;

endmodule
